// File: rtl/mesh_router.sv
// rtl/mesh_router.sv - 5-port XY wormhole mesh router with per-output credit flow control
// Input FIFOs feed per-output round-robin arbiters; a head flit holds its output until the tail leaves.
module mesh_router #(
   parameter int DATA_W  = 32,
   parameter int COORD_W = 4,
   parameter int DEPTH   = 4,
   parameter int MY_X    = 0,
   parameter int MY_Y    = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5*DATA_W-1:0] in_flit,
   input  logic [4:0]          in_valid,
   output logic [4:0]          credit_out,
   output logic [5*DATA_W-1:0] out_flit,
   output logic [4:0]          out_valid,
   input  logic [4:0]          credit_in,
   output logic [4:0]          overflow
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0]   mem_q [5][DEPTH];
   logic [PW-1:0]       rd_q [5];
   logic [PW-1:0]       wr_q [5];
   logic [CW-1:0]       cnt_q [5];
   logic [CW-1:0]       cred_q [5];
   logic [CW-1:0]       cred_d [5];
   logic [4:0]          rt_vld_q;
   logic [2:0]          rt_port_q [5];
   logic [4:0]          lock_q;
   logic [2:0]          lock_in_q [5];
   logic [2:0]          ptr_q [5];
   logic [2:0]          ptr_d [5];
   logic [5*DATA_W-1:0] out_flit_q;
   logic [4:0]          out_valid_q;
   logic [4:0]          credit_out_q;
   logic [4:0]          overflow_q;

   logic [DATA_W-1:0]   head_w [5];
   logic [2:0]          req_port [5];
   logic [4:0]          req_v;
   logic [4:0]          drop_v;
   logic [4:0]          pop_v;
   logic [4:0]          wr_v;
   logic [2:0]          gnt_in [5];
   logic [4:0]          gnt_v;

   function automatic logic [2:0] xy_route(input logic [2*COORD_W-1:0] dst);
      logic [COORD_W-1:0] dx;
      logic [COORD_W-1:0] dy;
      dx = dst[COORD_W-1:0];
      dy = dst[2*COORD_W-1:COORD_W];
      if (dx > COORD_W'(MY_X))      return 3'd2;
      else if (dx < COORD_W'(MY_X)) return 3'd4;
      else if (dy > COORD_W'(MY_Y)) return 3'd1;
      else if (dy < COORD_W'(MY_Y)) return 3'd3;
      return 3'd0;
   endfunction

   always_comb begin
      for (int p = 0; p < 5; p++) begin
         head_w[p]   = mem_q[p][rd_q[p]];
         req_v[p]    = 1'b0;
         drop_v[p]   = 1'b0;
         req_port[p] = 3'd0;
         if (cnt_q[p] != '0) begin
            // Types 01 and 11 both carry a destination; bit DATA_W-2 marks them.
            if (head_w[p][DATA_W-2]) begin
               req_v[p]    = 1'b1;
               req_port[p] = xy_route(head_w[p][2*COORD_W-1:0]);
            end else if (rt_vld_q[p]) begin
               req_v[p]    = 1'b1;
               req_port[p] = rt_port_q[p];
            end else begin
               drop_v[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      logic [2:0] idx;
      idx = 3'd0;
      for (int o = 0; o < 5; o++) begin
         gnt_v[o]  = 1'b0;
         gnt_in[o] = 3'd0;
         if (lock_q[o]) begin
            gnt_in[o] = lock_in_q[o];
            gnt_v[o]  = req_v[lock_in_q[o]] && (req_port[lock_in_q[o]] == 3'(o));
         end else begin
            for (int k = 0; k < 5; k++) begin
               idx = 3'((int'(ptr_q[o]) + k) % 5);
               if (!gnt_v[o] && req_v[idx] && (req_port[idx] == 3'(o))) begin
                  gnt_v[o]  = 1'b1;
                  gnt_in[o] = idx;
               end
            end
         end
         if (cred_q[o] == '0) gnt_v[o] = 1'b0;
      end
   end

   always_comb begin
      pop_v = drop_v;
      for (int o = 0; o < 5; o++) begin
         if (gnt_v[o]) pop_v[gnt_in[o]] = 1'b1;
         ptr_d[o]  = (gnt_in[o] == 3'd4) ? 3'd0 : gnt_in[o] + 3'd1;
         cred_d[o] = cred_q[o];
         if (gnt_v[o] && !credit_in[o])
            cred_d[o] = cred_q[o] - CW'(1);
         else if (!gnt_v[o] && credit_in[o] && (cred_q[o] != CW'(DEPTH)))
            cred_d[o] = cred_q[o] + CW'(1);
      end
      for (int p = 0; p < 5; p++)
         wr_v[p] = in_valid[p] && ((cnt_q[p] != CW'(DEPTH)) || pop_v[p]);
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 5; p++)
         if (wr_v[p]) mem_q[p][wr_q[p]] <= in_flit[p*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < 5; p++) begin
            rd_q[p]      <= '0;
            wr_q[p]      <= '0;
            cnt_q[p]     <= '0;
            cred_q[p]    <= CW'(DEPTH);
            rt_port_q[p] <= 3'd0;
            lock_in_q[p] <= 3'd0;
            ptr_q[p]     <= 3'd0;
         end
         rt_vld_q     <= '0;
         lock_q       <= '0;
         out_flit_q   <= '0;
         out_valid_q  <= '0;
         credit_out_q <= '0;
         overflow_q   <= '0;
      end else begin
         out_valid_q  <= gnt_v;
         credit_out_q <= pop_v;
         for (int p = 0; p < 5; p++) begin
            if (wr_v[p])  wr_q[p] <= wr_q[p] + PW'(1);
            if (pop_v[p]) rd_q[p] <= rd_q[p] + PW'(1);
            cnt_q[p] <= cnt_q[p] + CW'(wr_v[p]) - CW'(pop_v[p]);
            if (in_valid[p] && !wr_v[p]) overflow_q[p] <= 1'b1;
         end
         for (int o = 0; o < 5; o++) begin
            cred_q[o] <= cred_d[o];
            if (gnt_v[o]) begin
               out_flit_q[o*DATA_W +: DATA_W] <= head_w[gnt_in[o]];
               case (head_w[gnt_in[o]][DATA_W-1 -: 2])
                  2'b01: begin
                     lock_q[o]            <= 1'b1;
                     lock_in_q[o]         <= gnt_in[o];
                     rt_vld_q[gnt_in[o]]  <= 1'b1;
                     rt_port_q[gnt_in[o]] <= 3'(o);
                     ptr_q[o]             <= ptr_d[o];
                  end
                  2'b11: ptr_q[o] <= ptr_d[o];
                  2'b10: begin
                     lock_q[o]           <= 1'b0;
                     rt_vld_q[gnt_in[o]] <= 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign out_flit   = out_flit_q;
   assign out_valid  = out_valid_q;
   assign credit_out = credit_out_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_mesh_router.sv
// tb/tb_mesh_router.sv - directed and randomized checks of mesh_router against a queue-based model
module tb_mesh_router;
   localparam int DW  = 32;
   localparam int CWD = 4;
   localparam int DEP = 4;
   localparam int MX  = 1;
   localparam int MY  = 1;
   localparam int FW  = 5*DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [FW-1:0] in_flit = '0;
   logic [4:0]    in_valid = '0;
   logic [4:0]    credit_in = '0;
   logic [4:0]    credit_out;
   logic [4:0]    out_valid;
   logic [4:0]    overflow;
   logic [FW-1:0] out_flit;

   always #5 clk = ~clk;

   mesh_router #(.DATA_W(DW), .COORD_W(CWD), .DEPTH(DEP), .MY_X(MX), .MY_Y(MY)) dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .credit_out(credit_out), .out_flit(out_flit), .out_valid(out_valid),
      .credit_in(credit_in), .overflow(overflow)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference model: queues per input, integer credits, lock owner per output.
   logic [DW-1:0] q[5][$];
   int            cred[5];
   int            lock_own[5];
   int            ptr[5];
   int            rte[5];
   logic [FW-1:0] e_flit;
   logic [4:0]    e_val, e_cout, e_ov;
   int            sent_cnt = 0;

   function automatic int xy(input logic [DW-1:0] f);
      int dx, dy;
      dx = int'(f[CWD-1:0]);
      dy = int'(f[2*CWD-1:CWD]);
      if (dx > MX) return 2;
      if (dx < MX) return 4;
      if (dy > MY) return 1;
      if (dy < MY) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         q[i].delete();
         cred[i] = DEP; lock_own[i] = -1; ptr[i] = 0; rte[i] = -1;
      end
      e_flit = '0; e_val = '0; e_cout = '0; e_ov = '0;
   endtask

   task automatic model_step();
      int rq[5];
      bit dr[5];
      int gw[5];
      int i;
      logic [DW-1:0] f;
      for (int p = 0; p < 5; p++) begin
         rq[p] = -1; dr[p] = 0;
         if (q[p].size() > 0) begin
            f = q[p][0];
            if (f[DW-1:DW-2] == 2'b01 || f[DW-1:DW-2] == 2'b11) rq[p] = xy(f);
            else if (rte[p] >= 0) rq[p] = rte[p];
            else dr[p] = 1;
         end
      end
      for (int o = 0; o < 5; o++) begin
         gw[o] = -1;
         if (lock_own[o] >= 0) begin
            if (rq[lock_own[o]] == o) gw[o] = lock_own[o];
         end else begin
            for (int k = 0; k < 5; k++)
               if (gw[o] < 0 && rq[(ptr[o] + k) % 5] == o) gw[o] = (ptr[o] + k) % 5;
         end
         if (cred[o] == 0) gw[o] = -1;
      end
      e_val = '0; e_cout = '0;
      for (int o = 0; o < 5; o++) begin
         if (gw[o] >= 0) begin
            i = gw[o];
            f = q[i].pop_front();
            e_cout[i] = 1'b1; e_val[o] = 1'b1; e_flit[o*DW +: DW] = f;
            sent_cnt++;
            case (f[DW-1:DW-2])
               2'b01: begin lock_own[o] = i; rte[i] = o; ptr[o] = (i + 1) % 5; end
               2'b11: ptr[o] = (i + 1) % 5;
               2'b10: begin lock_own[o] = -1; rte[i] = -1; end
               default: ;
            endcase
         end
      end
      for (int p = 0; p < 5; p++)
         if (dr[p]) begin void'(q[p].pop_front()); e_cout[p] = 1'b1; end
      for (int o = 0; o < 5; o++) begin
         if (gw[o] >= 0 && !credit_in[o]) cred[o]--;
         else if (gw[o] < 0 && credit_in[o] && cred[o] < DEP) cred[o]++;
      end
      for (int p = 0; p < 5; p++)
         if (in_valid[p]) begin
            if (q[p].size() < DEP) q[p].push_back(in_flit[p*DW +: DW]);
            else e_ov[p] = 1'b1;
         end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("out_valid", FW'(out_valid), FW'(e_val));
         chk("out_flit", out_flit, e_flit);
         chk("credit_out", FW'(credit_out), FW'(e_cout));
         chk("overflow", FW'(overflow), FW'(e_ov));
      end
   end

   function automatic logic [DW-1:0] mk(input logic [1:0] t, input int dx, input int dy);
      logic [DW-1:0] f;
      f = $urandom;
      f[DW-1:DW-2] = t;
      f[2*CWD-1:0] = {CWD'(dy), CWD'(dx)};
      return f;
   endfunction

   task automatic put(input int p, input logic [DW-1:0] f);
      in_valid[p] = 1'b1;
      in_flit[p*DW +: DW] = f;
   endtask

   task automatic tick();
      @(negedge clk);
      in_valid = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = '0; credit_in = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] f;
      logic [DW-1:0] nf[3];
      logic [DW-1:0] wf[3];
      logic [DW-1:0] got[$];
      logic [1:0]    pt[3]  = '{2'b01, 2'b00, 2'b10};
      int            dxs[3] = '{1, 1, 0};
      int            dys[3] = '{1, 0, 3};
      logic [4:0]    exps[3] = '{5'b00001, 5'b01000, 5'b10000};
      int            rem[5];
      int            n;
      int            s0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", FW'(out_valid), '0);
      chk("rst_out_flit", out_flit, '0);
      chk("rst_credit_out", FW'(credit_out), '0);
      chk("rst_overflow", FW'(overflow), '0);
      rst = 1'b0;

      f = mk(2'b11, 3, 1);
      put(0, f);
      tick();
      chk("lat_early", FW'(out_valid), '0);
      tick();
      chk("lat_valid", FW'(out_valid), FW'(5'b00100));
      chk("lat_flit", FW'(out_flit[2*DW +: DW]), FW'(f));
      chk("lat_credit", FW'(credit_out), FW'(5'b00001));
      tick();
      chk("lat_done", FW'({out_valid, credit_out}), '0);

      for (int k = 0; k < 3; k++) begin
         put(0, mk(2'b11, dxs[k], dys[k]));
         tick();
         tick();
         chk("route_dir", FW'(out_valid), FW'(exps[k]));
      end

      do_reset();
      credit_in = 5'b11111;
      for (int k = 0; k < 3; k++) begin
         nf[k] = mk(pt[k], 3, 1);
         wf[k] = mk(pt[k], 3, 1);
      end
      got.delete();
      for (int c = 0; c < 12; c++) begin
         if (c < 3) begin put(1, nf[c]); put(4, wf[c]); end
         tick();
         if (out_valid[2]) got.push_back(out_flit[2*DW +: DW]);
      end
      chk("rr_count", FW'(got.size()), FW'(6));
      for (int k = 0; k < 6 && k < got.size(); k++)
         chk("rr_order", FW'(got[k]), FW'(k < 3 ? nf[k] : wf[k-3]));

      do_reset();
      n = 0;
      for (int c = 0; c < 16; c++) begin
         if (c < DEP + 2) put(0, mk(2'b11, 3, 1));
         tick();
         if (out_valid[2]) n++;
      end
      chk("credit_stall_sent", FW'(n), FW'(DEP));
      chk("credit_stall_ovf", FW'(overflow), '0);
      n = 0;
      credit_in = 5'b00100;
      tick();
      credit_in = '0;
      if (out_valid[2]) n++;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid[2]) n++;
      end
      chk("credit_release", FW'(n), FW'(1));

      do_reset();
      for (int c = 0; c < 2*DEP + 1; c++) begin
         if (c < DEP) put(0, mk(2'b11, 3, 1));
         else put(1, mk(2'b11, 3, 1));
         tick();
      end
      repeat (3) tick();
      chk("ovf_set", FW'(overflow), FW'(5'b00010));
      repeat (5) tick();
      chk("ovf_sticky", FW'(overflow), FW'(5'b00010));
      do_reset();
      chk("ovf_clear", FW'(overflow), '0);

      credit_in = 5'b11111;
      put(0, mk(2'b01, 3, 1));
      tick();
      put(0, mk(2'b00, 3, 1));
      tick();
      chk("mid_pkt_head", FW'(out_valid), FW'(5'b00100));
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", FW'(out_valid), '0);
      chk("mid_rst_flit", out_flit, '0);
      chk("mid_rst_credit", FW'(credit_out), '0);
      @(negedge clk);
      rst = 1'b0; credit_in = '0; in_valid = '0;
      tick();
      chk("post_rst_quiet", FW'({out_valid, credit_out}), '0);
      n = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < DEP) put(0, mk(2'b11, 3, 1));
         tick();
         if (out_valid[2]) n++;
      end
      chk("post_rst_credits", FW'(n), FW'(DEP));

      do_reset();
      s0 = sent_cnt;
      for (int i = 0; i < 5; i++) rem[i] = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int o = 0; o < 5; o++) credit_in[o] = ($urandom_range(0, 99) < 35);
         for (int i = 0; i < 5; i++) begin
            if (q[i].size() < DEP && $urandom_range(0, 99) < 55) begin
               if (rem[i] == 0) begin
                  n = int'($urandom_range(1, 4));
                  f = mk(n == 1 ? 2'b11 : 2'b01, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                  rem[i] = n - 1;
               end else begin
                  rem[i]--;
                  f = mk(rem[i] == 0 ? 2'b10 : 2'b00, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
               end
               put(i, f);
            end
         end
         tick();
      end
      credit_in = 5'b11111;
      repeat (30) tick();
      chk("random_traffic", FW'((sent_cnt - s0) > 300), FW'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mesh_router.md
MESH_ROUTER -- requirements
Module: mesh_router

Interface
REQ-001 Parameter DATA_W, default 32: flit width in bits; SHALL be >= 2*COORD_W+2.
REQ-002 Parameter COORD_W, default 4: width of each X/Y mesh coordinate.
REQ-003 Parameter DEPTH, default 4: input FIFO depth per port and initial credit count per output; power of 2, >= 2.
REQ-004 Parameter MY_X, default 0: this router's X coordinate.
REQ-005 Parameter MY_Y, default 0: this router's Y coordinate.
REQ-006 clk  input  1  single clock for all state; rising-edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_flit  input  5*DATA_W  packed input flits; slice p = port p (0 local/PE, 1 north, 2 east, 3 south, 4 west).
REQ-009 in_valid  input  5  per-port flit-present strobe.
REQ-010 credit_out  output  5  per-port one-cycle pulse to upstream: one input FIFO slot freed.
REQ-011 out_flit  output  5*DATA_W  packed registered output flits, same port order.
REQ-012 out_valid  output  5  per-port registered output strobe.
REQ-013 credit_in  input  5  per-port one-cycle pulse from downstream: one downstream slot freed.
REQ-014 overflow  output  5  sticky per-port error: write attempted while input FIFO full.

Function
REQ-015 Flit type SHALL be flit[DATA_W-1:DATA_W-2]: 01 head, 00 body, 10 tail, 11 single (head+tail).
REQ-016 Head/single flits SHALL carry dest X in flit[COORD_W-1:0] and dest Y in flit[2*COORD_W-1:COORD_W].
REQ-017 Each input port SHALL have a DEPTH-entry FIFO; in_valid high at edge k writes in_flit slice; write to full FIFO dropped and sets overflow[p].
REQ-018 Simultaneous write and read on a full FIFO SHALL both occur (no overflow); pointers wrap modulo DEPTH.
REQ-019 Routing SHALL be XY on FIFO-head flit: destX>MY_X east; destX<MY_X west; else destY>MY_Y north; destY<MY_Y south; else local.
REQ-020 Route of a head SHALL be latched per input and reused for body/tail flits of the same packet.
REQ-021 Each output SHALL run a round-robin arbiter over requesting inputs, priority starting at pointer; pointer SHALL move to winner+1 (mod 5) after each head/single grant.
REQ-022 Wormhole: a granted head (type 01) SHALL lock its output to that input; lock SHALL release in the cycle the tail is sent; locked output ignores other requesters.
REQ-023 A flit SHALL be sent only if its FIFO is non-empty, it holds/wins the output, and that output's credit counter > 0.
REQ-024 Send: FIFO pops, out_flit/out_valid registered at the same edge, credit_out[p] pulses high for exactly the following cycle.
REQ-025 Latency: flit sampled at edge k, uncontested with credit, SHALL appear with out_valid high after edge k+1; one flit per output per cycle throughput.
REQ-026 out_valid SHALL be 0 in any cycle without a send; out_flit holds last value.
REQ-027 Credit counter per output, width clog2(DEPTH+1), SHALL decrement on send, increment on credit_in, unchanged when both; saturate at DEPTH.
REQ-028 Body/tail flit at FIFO head with no latched route (protocol error) SHALL be dropped in one cycle without output.

Reset
REQ-029 While rst high: FIFOs empty, all route latches/locks cleared, RR pointers 0, credit counters = DEPTH, out_valid=0, out_flit=0, credit_out=0, overflow=0.
REQ-030 rst mid-packet SHALL discard all buffered flits; no output or credit pulse in the first cycle after deassertion.

Verification
REQ-031 MY=(1,1): single flit dest (3,1) on local at edge 0 -> out_valid[2]=1 after edge 1, credit_out[0]=1 next cycle.
REQ-032 North and west both send 3-flit packets to east simultaneously -> north (lower index from pointer 0) packet fully sent first, no interleave, west follows.
REQ-033 Hold credit_in[2]=0, send DEPTH+2 single flits east -> exactly DEPTH sent, remainder buffered; one credit_in pulse releases exactly one flit.
REQ-034 DEPTH+1 writes on north with output blocked -> overflow[1]=1 and stays 1 until rst.
REQ-035 Dest (1,1) at router (1,1) -> local out; dest (1,0) -> south; dest (0,3) -> west.
REQ-036 Assert rst mid-packet -> all outputs 0 immediately; new packet after release routes normally with full credits.
